a2d_arbiter: RTL and testbench
==============================

// Module: a2d_arbiter
// PURPOSE
//  Shares the single A2D converter interface (strt_cnv/chnnl/cnv_cmplt/res) between two requesters.
//  Port 0 is the IR motion controller; port 1 is housekeeping (battery / diagnostics).
//  Round-robin grant, one conversion per grant, result latched and returned with a done pulse.
//  A watchdog aborts a conversion whose cnv_cmplt never arrives.
// PARAMETERS
//  RES_W       12    A2D result width
//  TIMEOUT_CYC 1023  WAIT-state cycles before abort (1..2^TO_W-1)
//  TO_W        10    watchdog counter width
// PORTS
//  clk        in   1      system clock, all flops rise-edge
//  rst_n      in   1      asynchronous active-low reset
//  req0       in   1      requester 0 conversion request (level, held until done0)
//  chnnl0     in   3      requester 0 channel select, stable while req0 high
//  gnt0       out  1      requester 0 owns the converter
//  done0      out  1      1-cycle pulse: res valid for requester 0
//  req1       in   1      requester 1 conversion request
//  chnnl1     in   3      requester 1 channel select
//  gnt1       out  1      requester 1 owns the converter
//  done1      out  1      1-cycle pulse: res valid for requester 1
//  res        out  RES_W  latched result of last completed/aborted conversion
//  strt_cnv   out  1      to A2D: 1-cycle start pulse
//  chnnl      out  3      to A2D: channel, registered at grant
//  cnv_cmplt  in   1      from A2D: conversion complete (pulse or level)
//  A2D_res    in   RES_W  from A2D: result, valid when cnv_cmplt high
//  timeout_err out 1      sticky: a conversion was aborted by the watchdog
// BEHAVIOUR
//  Reset: state=IDLE, gnt0/gnt1/done0/done1/strt_cnv/timeout_err=0, chnnl=0, res=0,
//   last_srv=1 (so req0 wins the first tie), watchdog=0. Reset mid-conversion abandons it; no done.
//  All outputs are registered.
//  States: IDLE -> START -> WAIT -> DONE -> IDLE.
//  IDLE: req sampled only here. Neither req: stay. One req: grant it.
//   Both req: grant the one != last_srv. On grant: gnt_x<=1, chnnl<=chnnl_x,
//   strt_cnv<=1, last_srv<=x, go START.
//  START (1 cycle): strt_cnv<=0, watchdog<=0, go WAIT. cnv_cmplt here is ignored
//   (it belongs to no conversion this block started).
//  WAIT: watchdog increments every cycle.
//   cnv_cmplt=1: res<=A2D_res, done_x<=1, gnt_x<=0, go DONE.
//   else watchdog==TIMEOUT_CYC-1: res<={RES_W{1'b1}}, done_x<=1, gnt_x<=0,
//   timeout_err<=1, go DONE.
//   cnv_cmplt and timeout on the same cycle: completion wins, no error.
//  DONE (1 cycle): done_x<=0, go IDLE. res holds until the next DONE entry.
//  Requester rule: drop req on the edge where done_x is seen high; a req still high
//   in IDLE is treated as a new request (round-robin still applies).
//  chnnl holds its value outside grants. gnt0 and gnt1 are never high together.
//  Latency: req in IDLE at edge k -> strt_cnv high cycle k+1; cnv_cmplt sampled at
//   edge m -> done high cycle m+1. Request-to-done minimum 4 cycles.
//  Dropped req while granted: conversion still completes; done still pulses.
//  timeout_err clears only on rst_n.
// TESTING
//  Single req0, chnnl0=3'd5, cnv_cmplt 10 cycles after strt_cnv with A2D_res=12'd354
//   -> chnnl=5, one strt_cnv pulse, done0 one cycle, res=354, done1 never high.
//  req0 and req1 high together from reset, A2D_res 712 then 100 -> port 0 served first
//   (res=712, done0), then port 1 (res=100, done1); gnt never overlaps.
//  Both held high through 4 conversions -> grant order 0,1,0,1.
//  req1, cnv_cmplt never asserted, TIMEOUT_CYC=16 -> done1 16 cycles after entering WAIT,
//   res=12'hFFF, timeout_err=1 and stays 1 through a later good conversion.
//  cnv_cmplt pulsed during START and IDLE -> ignored, no done, res unchanged.
//  rst_n low during WAIT -> all outputs return to reset values immediately, no done pulse;
//   after release a new req0 is serviced normally.

Source files
------------

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: round-robin sharing of one A2D converter between two requesters, with a conversion watchdog
module a2d_arbiter #(
    parameter int RES_W       = 12,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [2:0]       chnnl0,
    output logic             gnt0,
    output logic             done0,
    input  logic             req1,
    input  logic [2:0]       chnnl1,
    output logic             gnt1,
    output logic             done1,
    output logic [RES_W-1:0] res,
    output logic             strt_cnv,
    output logic [2:0]       chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] A2D_res,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
    state_t           state, state_nxt;
    logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, strt_nxt, to_nxt, last_srv, last_nxt;
    logic [2:0]       chnnl_nxt;
    logic [RES_W-1:0] res_nxt;
    logic [TO_W-1:0]  wd, wd_nxt;
    logic             pick0, expired;

    // req0 wins when alone or when port 1 was served last
    assign pick0   = req0 && (!req1 || last_srv);
    assign expired = wd == TO_W'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            strt_cnv    <= 1'b0;
            timeout_err <= 1'b0;
            chnnl       <= '0;
            res         <= '0;
            last_srv    <= 1'b1;
            wd          <= '0;
        end else begin
            state       <= state_nxt;
            gnt0        <= gnt0_nxt;
            gnt1        <= gnt1_nxt;
            done0       <= done0_nxt;
            done1       <= done1_nxt;
            strt_cnv    <= strt_nxt;
            timeout_err <= to_nxt;
            chnnl       <= chnnl_nxt;
            res         <= res_nxt;
            last_srv    <= last_nxt;
            wd          <= wd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0_nxt  = gnt0;
        gnt1_nxt  = gnt1;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        strt_nxt  = 1'b0;
        to_nxt    = timeout_err;
        chnnl_nxt = chnnl;
        res_nxt   = res;
        last_nxt  = last_srv;
        wd_nxt    = wd;
        case (state)
            IDLE: if (req0 || req1) begin
                gnt0_nxt  = pick0;
                gnt1_nxt  = !pick0;
                chnnl_nxt = pick0 ? chnnl0 : chnnl1;
                strt_nxt  = 1'b1;
                last_nxt  = !pick0;
                state_nxt = START;
            end
            START: begin
                wd_nxt    = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                wd_nxt = wd + 1'b1;
                // completion takes priority over a simultaneous watchdog expiry
                if (cnv_cmplt || expired) begin
                    res_nxt   = cnv_cmplt ? A2D_res : {RES_W{1'b1}};
                    to_nxt    = timeout_err | !cnv_cmplt;
                    done0_nxt = gnt0;
                    done1_nxt = gnt1;
                    gnt0_nxt  = 1'b0;
                    gnt1_nxt  = 1'b0;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: table-driven conversions plus hand sequences for spurious completes and mid-conversion reset
module tb_a2d_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, cnv_cmplt = 1'b0;
    logic [2:0]  chnnl0 = '0, chnnl1 = '0, chnnl;
    logic [11:0] A2D_res = '0, res;
    logic        gnt0, gnt1, done0, done1, strt_cnv, timeout_err;
    int          checks = 0, failures = 0;

    a2d_arbiter #(.RES_W(12), .TIMEOUT_CYC(16), .TO_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .chnnl0(chnnl0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .chnnl1(chnnl1), .gnt1(gnt1), .done1(done1),
        .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1;
        logic [2:0]  c0, c1;
        int          dly;
        logic [11:0] val;
        logic        spulse;
        int          port;
        logic [2:0]  ech;
        logic [11:0] eres;
        logic        eto;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n) chk("gnt_overlap", {31'd0, gnt0 & gnt1}, 32'd0);

    // dly>0: cnv_cmplt asserted dly cycles after strt_cnv; dly==0: never asserted (watchdog path)
    task automatic run(input vec_t v);
        int n;
        req0 = v.r0; req1 = v.r1; chnnl0 = v.c0; chnnl1 = v.c1;
        n = 0;
        do begin @(negedge clk); n++; end while (!strt_cnv && n < 10);
        chk("strt", {31'd0, strt_cnv}, 32'd1);
        chk("gnt", {30'd0, gnt1, gnt0}, v.port ? 32'd2 : 32'd1);
        chk("chnnl", {29'd0, chnnl}, {29'd0, v.ech});
        cnv_cmplt = v.spulse; A2D_res = 12'h0EE;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        chk("start_ignore", {30'd0, done1, done0}, 32'd0);
        chk("strt_pulse", {31'd0, strt_cnv}, 32'd0);
        if (v.dly > 0) begin
            repeat (v.dly - 1) @(negedge clk);
            cnv_cmplt = 1'b1; A2D_res = v.val;
            @(negedge clk);
            cnv_cmplt = 1'b0; A2D_res = '0;
        end else begin
            n = 1;
            while (!(done0 || done1) && n < 40) begin @(negedge clk); n++; end
            chk("timeout_lat", n, 32'd17);
        end
        chk("done", {30'd0, done1, done0}, v.port ? 32'd2 : 32'd1);
        chk("res", {20'd0, res}, {20'd0, v.eres});
        chk("gnt_off", {30'd0, gnt1, gnt0}, 32'd0);
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, v.eto});
        @(negedge clk);
        chk("done_pulse", {30'd0, done1, done0}, 32'd0);
    endtask

    vec_t tbl[8];
    vec_t post;

    initial begin
        tbl[0] = '{1, 1, 3'd2, 3'd6, 3,  12'd712, 0, 0, 3'd2, 12'd712, 0};
        tbl[1] = '{1, 1, 3'd2, 3'd6, 4,  12'd100, 0, 1, 3'd6, 12'd100, 0};
        tbl[2] = '{1, 1, 3'd2, 3'd6, 1,  12'h055, 0, 0, 3'd2, 12'h055, 0};
        tbl[3] = '{1, 1, 3'd2, 3'd6, 2,  12'h077, 0, 1, 3'd6, 12'h077, 0};
        tbl[4] = '{1, 0, 3'd5, 3'd0, 10, 12'd354, 0, 0, 3'd5, 12'd354, 0};
        tbl[5] = '{0, 1, 3'd0, 3'd3, 0,  12'd0,   0, 1, 3'd3, 12'hFFF, 1};
        tbl[6] = '{0, 1, 3'd0, 3'd4, 2,  12'h123, 0, 1, 3'd4, 12'h123, 1};
        tbl[7] = '{1, 0, 3'd7, 3'd0, 1,  12'h456, 1, 0, 3'd7, 12'h456, 1};
        post   = '{1, 0, 3'd6, 3'd0, 2,  12'h2AA, 0, 0, 3'd6, 12'h2AA, 0};
        req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'd2; chnnl1 = 3'd6;
        repeat (2) @(negedge clk);
        chk("reset_outs", {gnt0, gnt1, done0, done1, strt_cnv, timeout_err, chnnl, res}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) run(tbl[i]);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        cnv_cmplt = 1'b1; A2D_res = 12'hABC;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        chk("idle_ignore_done", {30'd0, done1, done0}, 32'd0);
        @(negedge clk);
        chk("idle_ignore_res", {20'd0, res}, 32'h456);
        chk("idle_ignore_gnt", {30'd0, gnt1, gnt0, strt_cnv}, 32'd0);
        req0 = 1'b1; chnnl0 = 3'd1;
        for (int n = 0; n < 10 && !strt_cnv; n++) @(negedge clk);
        chk("rst_strt", {31'd0, strt_cnv}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_wait_outs", {gnt0, gnt1, done0, done1, strt_cnv, timeout_err, chnnl, res}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_no_done", {30'd0, done1, done0}, 32'd0);
        run(post);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
